cell_exhaustive_checker: RTL and testbench

- Sequential stimulus/response harness that sits directly around a small combinational standard cell: it drives the cell's inputs and consumes its output.
- The default configuration targets a 3-input AOI21 (Y = ~((A0&A1)|B)).
- Steps through all 2^N_IN input vectors, waits a settle interval, samples the cell output and compares it against a parameterised truth table.
- Reports pass/fail, the failure count and the first failing vector. Used for silicon bring-up and gate-level regression of library cells.

---
 rtl/cell_exhaustive_checker.sv | 92 +++++++++
 tb/tb_cell_exhaustive_checker.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_exhaustive_checker.sv
// cell_exhaustive_checker: sweeps every input vector of a small combinational cell and
// compares its settled output against a truth table, keeping pass/fail and first-failure results.
module cell_exhaustive_checker #(
  parameter int N_IN = 3,
  parameter logic [(1<<N_IN)-1:0] TRUTH = 8'h07,
  parameter int SETTLE_CYC = 2
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            START,
  input  logic            ABORT,
  input  logic            Y,
  output logic [N_IN-1:0] VEC,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [N_IN:0]   FAIL_CNT,
  output logic            FIRST_FAIL_VLD,
  output logic [N_IN-1:0] FIRST_FAIL_VEC
);
  localparam int CW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYC - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FIN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state          <= IDLE;
      cnt            <= '0;
      VEC            <= '0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      PASS           <= 1'b0;
      FAIL_CNT       <= '0;
      FIRST_FAIL_VLD <= 1'b0;
      FIRST_FAIL_VEC <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START && !ABORT) begin
          VEC            <= '0;
          FAIL_CNT       <= '0;
          FIRST_FAIL_VLD <= 1'b0;
          PASS           <= 1'b0;
          cnt            <= CNT_INIT;
          BUSY           <= 1'b1;
          state          <= SETTLE;
        end
        SETTLE: if (ABORT) begin
          state <= IDLE;
          VEC   <= '0;
          BUSY  <= 1'b0;
          PASS  <= 1'b0;
        end else if (cnt == '0) begin
          state <= SAMPLE;
        end else begin
          cnt <= cnt - 1'b1;
        end
        SAMPLE: if (ABORT) begin
          state <= IDLE;
          VEC   <= '0;
          BUSY  <= 1'b0;
          PASS  <= 1'b0;
        end else begin
          if (Y != TRUTH[VEC]) begin
            FAIL_CNT <= FAIL_CNT + 1'b1;
            if (!FIRST_FAIL_VLD) begin
              FIRST_FAIL_VLD <= 1'b1;
              FIRST_FAIL_VEC <= VEC;
            end
          end
          // DONE is raised on entry so the pulse coincides with the FIN cycle
          if (&VEC) begin
            state <= FIN;
            DONE  <= 1'b1;
          end else begin
            VEC   <= VEC + 1'b1;
            cnt   <= CNT_INIT;
            state <= SETTLE;
          end
        end
        FIN: begin
          BUSY  <= 1'b0;
          PASS  <= FAIL_CNT == '0;
          VEC   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cell_exhaustive_checker.sv
// tb_cell_exhaustive_checker: directed scenarios around an AOI21 model with selectable faults.
module tb_cell_exhaustive_checker;
  logic clk, rn, start, abort, y;
  logic [1:0] mode;
  logic [2:0] vec, ffvec;
  logic busy, done, pass, ffv;
  logic [3:0] fail_cnt;
  logic start2, abort2, y2;
  logic [2:0] vec2, ffvec2;
  logic busy2, done2, pass2, ffv2;
  logic [3:0] fail_cnt2;
  int vectors = 0;
  int miscompares = 0;

  cell_exhaustive_checker #(.N_IN(3), .TRUTH(8'h07), .SETTLE_CYC(2)) dut (
    .CLK(clk), .RN(rn), .START(start), .ABORT(abort), .Y(y), .VEC(vec), .BUSY(busy),
    .DONE(done), .PASS(pass), .FAIL_CNT(fail_cnt), .FIRST_FAIL_VLD(ffv), .FIRST_FAIL_VEC(ffvec));

  cell_exhaustive_checker #(.N_IN(3), .TRUTH(8'h07), .SETTLE_CYC(1)) dut2 (
    .CLK(clk), .RN(rn), .START(start2), .ABORT(abort2), .Y(y2), .VEC(vec2), .BUSY(busy2),
    .DONE(done2), .PASS(pass2), .FAIL_CNT(fail_cnt2), .FIRST_FAIL_VLD(ffv2), .FIRST_FAIL_VEC(ffvec2));

  // mode 0: ideal AOI21, 1: stuck at 1, 2: missing AND term (Y=~B)
  always_comb y = mode == 2'd0 ? ~((vec[0] & vec[1]) | vec[2]) : mode == 2'd1 ? 1'b1 : ~vec[2];
  always_comb y2 = ~((vec2[0] & vec2[1]) | vec2[2]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(output int at);
    at = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin
        at = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rn = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0; mode = 2'd0;
    #12;
    vectors++;
    if ({vec, busy, done, pass, fail_cnt, ffv, ffvec} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset: outputs=%b expected all zero", {vec, busy, done, pass, fail_cnt, ffv, ffvec});
    end
    @(negedge clk) rn = 1'b1;
  endtask

  task automatic test_ideal();
    mode = 2'd0;
    pulse_start();
    vectors++;
    if ({busy, vec} !== 4'b1000) begin
      miscompares++;
      $display("FAIL ideal_start: busy,vec=%b expected 1000", {busy, vec});
    end
    for (int n = 1; n <= 24; n++) begin
      logic [3:0] exp;
      @(negedge clk);
      exp = n == 24 ? 4'b1111 : {1'b0, 3'(n / 3)};
      vectors++;
      if ({done, vec} !== exp) begin
        miscompares++;
        $display("FAIL ideal_cycle%0d: done,vec=%b expected %b", n, {done, vec}, exp);
      end
    end
    @(negedge clk);
    vectors++;
    if ({busy, done, pass, fail_cnt, ffv, vec} !== 11'b00100000000) begin
      miscompares++;
      $display("FAIL ideal_result: busy,done,pass,fail_cnt,ffv,vec=%b expected 00100000000",
               {busy, done, pass, fail_cnt, ffv, vec});
    end
  endtask

  task automatic test_abort_settle();
    int seen;
    mode = 2'd0;
    pulse_start();
    for (int n = 1; n <= 9; n++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    vectors++;
    if ({busy, done, pass, vec} !== 6'd0) begin
      miscompares++;
      $display("FAIL abort_settle: busy,done,pass,vec=%b expected 000000", {busy, done, pass, vec});
    end
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done: done/busy seen=%0d expected 0", seen);
    end
  endtask

  task automatic test_stuck1();
    int at;
    mode = 2'd1;
    pulse_start();
    wait_done(at);
    vectors++;
    if (at !== 24) begin
      miscompares++;
      $display("FAIL stuck1_latency: done at %0d expected 24", at);
    end
    @(negedge clk);
    vectors++;
    if ({pass, fail_cnt, ffv, ffvec} !== {1'b0, 4'd5, 1'b1, 3'd3}) begin
      miscompares++;
      $display("FAIL stuck1_result: pass=%b fail_cnt=%0d ffv=%b ffvec=%0d expected 0 5 1 3",
               pass, fail_cnt, ffv, ffvec);
    end
  endtask

  task automatic test_missing_and();
    int at;
    mode = 2'd2;
    pulse_start();
    wait_done(at);
    @(negedge clk);
    vectors++;
    if ({pass, fail_cnt, ffv, ffvec} !== {1'b0, 4'd1, 1'b1, 3'd3}) begin
      miscompares++;
      $display("FAIL missing_and: pass=%b fail_cnt=%0d ffv=%b ffvec=%0d expected 0 1 1 3",
               pass, fail_cnt, ffv, ffvec);
    end
  endtask

  task automatic test_abort_in_sample();
    mode = 2'd1;
    pulse_start();
    for (int n = 1; n <= 11; n++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    vectors++;
    if ({busy, fail_cnt, ffv} !== 6'd0) begin
      miscompares++;
      $display("FAIL abort_in_sample: busy=%b fail_cnt=%0d ffv=%b expected 0 0 0", busy, fail_cnt, ffv);
    end
  endtask

  task automatic test_abort_partial();
    mode = 2'd1;
    pulse_start();
    for (int n = 1; n <= 15; n++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, fail_cnt, ffv, ffvec} !== {1'b0, 4'd2, 1'b1, 3'd3}) begin
      miscompares++;
      $display("FAIL abort_partial: busy=%b fail_cnt=%0d ffv=%b ffvec=%0d expected 0 2 1 3",
               busy, fail_cnt, ffv, ffvec);
    end
  endtask

  task automatic test_start_ignored();
    int at, pulses;
    mode = 2'd0;
    pulse_start();
    at = 0; pulses = 0;
    for (int n = 1; n <= 30; n++) begin
      start = n == 5 || n == 12;
      @(negedge clk);
      if (done) begin
        pulses++;
        at = n;
      end
    end
    start = 1'b0;
    vectors++;
    if (at !== 24 || pulses !== 1) begin
      miscompares++;
      $display("FAIL start_ignored: done at %0d pulses %0d expected 24 1", at, pulses);
    end
    vectors++;
    if ({busy, pass, fail_cnt} !== 6'b010000) begin
      miscompares++;
      $display("FAIL start_ignored_result: busy=%b pass=%b fail_cnt=%0d expected 0 1 0", busy, pass, fail_cnt);
    end
  endtask

  task automatic test_abort_in_fin();
    mode = 2'd1;
    pulse_start();
    for (int n = 1; n <= 24; n++) @(negedge clk);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL fin_done: done=%b expected 1", done);
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    vectors++;
    if ({busy, done, pass, fail_cnt, vec} !== {3'b000, 4'd5, 3'd0}) begin
      miscompares++;
      $display("FAIL abort_in_fin: busy=%b done=%b pass=%b fail_cnt=%0d vec=%0d expected 0 0 0 5 0",
               busy, done, pass, fail_cnt, vec);
    end
  endtask

  task automatic test_async_reset();
    int at;
    mode = 2'd1;
    pulse_start();
    for (int n = 1; n <= 15; n++) @(negedge clk);
    #2 rn = 1'b0;
    #1;
    vectors++;
    if ({vec, busy, done, pass, fail_cnt, ffv, ffvec} !== 14'd0) begin
      miscompares++;
      $display("FAIL async_reset: outputs=%b expected all zero", {vec, busy, done, pass, fail_cnt, ffv, ffvec});
    end
    @(negedge clk) rn = 1'b1;
    mode = 2'd0;
    pulse_start();
    wait_done(at);
    @(negedge clk);
    vectors++;
    if (at !== 24 || {pass, fail_cnt, ffv} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_recover: done at %0d pass=%b fail_cnt=%0d ffv=%b expected 24 1 0 0",
               at, pass, fail_cnt, ffv);
    end
  endtask

  task automatic test_settle1();
    int at;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    at = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done2) begin
        at = n;
        break;
      end
    end
    vectors++;
    if (at !== 16) begin
      miscompares++;
      $display("FAIL settle1_latency: done at %0d expected 16", at);
    end
    @(negedge clk);
    vectors++;
    if ({busy2, pass2, fail_cnt2, ffv2} !== 7'b0100000) begin
      miscompares++;
      $display("FAIL settle1_result: busy=%b pass=%b fail_cnt=%0d ffv=%b expected 0 1 0 0",
               busy2, pass2, fail_cnt2, ffv2);
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    start = 1'b1; abort = 1'b1; start2 = 1'b1; abort2 = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, busy2, pass, pass2, vec} !== {4'b0011, 3'd0}) begin
      miscompares++;
      $display("FAIL start_abort_idle: busy=%b busy2=%b pass=%b pass2=%b vec=%0d expected 0 0 1 1 0",
               busy, busy2, pass, pass2, vec);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_abort_settle();
    test_stuck1();
    test_missing_and();
    test_abort_in_sample();
    test_abort_partial();
    test_start_ignored();
    test_abort_in_fin();
    test_async_reset();
    test_settle1();
    test_start_abort_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
